// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the multi-channel PWM block.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam int   MIN_PERIOD  = 2;

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN
    } state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending duty, threshold scaled to the period, compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int CNT_W  = 12,
    parameter int DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              duty_we,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              load,
    input  logic [CNT_W-1:0]  period_pend,
    input  logic [CNT_W-1:0]  period_act,
    input  logic              mode_act,
    input  logic [CNT_W-1:0]  cnt,
    output logic              pwm
);

    logic [DUTY_W-1:0] duty_pend;
    logic [CNT_W-1:0]  thr;
    logic [CNT_W-1:0]  thr_next;
    logic              hit;

    // All-ones duty maps to the full period so the output can reach 100%.
    always_comb begin
        if (&duty_pend) begin
            thr_next = period_pend;
        end else begin
            thr_next = CNT_W'(({{DUTY_W{1'b0}}, period_pend} *
                               {{CNT_W{1'b0}}, duty_pend}) >> DUTY_W);
        end
    end

    always_comb begin
        if (mode_act == MODE_CENTER) begin
            hit = (cnt >= period_act - thr);
        end else begin
            hit = (cnt < thr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_pend <= '0;
            thr       <= '0;
            pwm       <= 1'b0;
        end else begin
            if (duty_we) begin
                duty_pend <= duty_in;
            end
            if (load) begin
                thr <= thr_next;
            end
            pwm <= en & hit;
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared period counter, shadowed period/mode/duty,
// loads only at a period boundary; edge- and center-aligned modes.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CNT_W          = 12,
    parameter int DUTY_W         = 8,
    parameter int DEFAULT_PERIOD = 2500,
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                period_we,
    input  logic [CNT_W-1:0]    period_in,
    input  logic                duty_we,
    input  logic [CH_W-1:0]     duty_ch,
    input  logic [DUTY_W-1:0]   duty_in,
    input  logic                center_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] period_pend;
    logic [CNT_W-1:0] period_act;
    logic             mode_pend;
    logic             mode_act;
    logic             last;
    logic             boundary;
    logic             load;

    always_comb begin
        last = (cnt == period_act - CNT_W'(1));
        if (mode_act == MODE_CENTER) begin
            boundary = (state == DOWN) && (cnt == '0);
        end else begin
            boundary = (state != DOWN) && last;
        end
        load        = !en || boundary;
        period_tick = en && boundary;
    end

    // IDLE with en high is the first up-count cycle (counter 0).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (!en) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            unique case (state)
                IDLE, UP: begin
                    if (last) begin
                        if (mode_act == MODE_CENTER) begin
                            state_next = DOWN;
                        end else begin
                            state_next = UP;
                            cnt_next   = '0;
                        end
                    end else begin
                        state_next = UP;
                        cnt_next   = cnt + CNT_W'(1);
                    end
                end
                DOWN: begin
                    if (cnt == '0) begin
                        state_next = UP;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            period_pend <= CNT_W'(DEFAULT_PERIOD);
            period_act  <= CNT_W'(DEFAULT_PERIOD);
            mode_pend   <= MODE_EDGE;
            mode_act    <= MODE_EDGE;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mode_pend <= center_mode;
            if (period_we) begin
                if (period_in < CNT_W'(MIN_PERIOD)) begin
                    period_pend <= CNT_W'(MIN_PERIOD);
                end else begin
                    period_pend <= period_in;
                end
            end
            if (load) begin
                period_act <= period_pend;
                mode_act   <= mode_pend;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .CNT_W  (CNT_W),
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .duty_we     (duty_we && (duty_ch == CH_W'(i))),
            .duty_in     (duty_in),
            .load        (load),
            .period_pend (period_pend),
            .period_act  (period_act),
            .mode_act    (mode_act),
            .cnt         (cnt),
            .pwm         (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel (4-channel DUT plus a 3-channel
// instance that must ignore writes to channel 3).
module tb_pwm_multi_channel;

    localparam int CH  = 4;
    localparam int CW  = 12;
    localparam int DW  = 8;
    localparam int DEF = 2500;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          period_we = 1'b0;
    logic [CW-1:0] period_in = '0;
    logic          duty_we = 1'b0;
    logic [1:0]    duty_ch = '0;
    logic [DW-1:0] duty_in = '0;
    logic          center_mode = 1'b0;
    logic [CH-1:0] pwm_out;
    logic          period_tick;
    logic [2:0]    pwm3;
    logic          tick3;

    always #5 clk = ~clk;

    pwm_multi_channel #(
        .CHANNELS(CH), .CNT_W(CW), .DUTY_W(DW), .DEFAULT_PERIOD(DEF)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en),
        .period_we(period_we), .period_in(period_in),
        .duty_we(duty_we), .duty_ch(duty_ch), .duty_in(duty_in),
        .center_mode(center_mode),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    pwm_multi_channel #(
        .CHANNELS(3), .CNT_W(CW), .DUTY_W(DW), .DEFAULT_PERIOD(DEF)
    ) u_dut3 (
        .clk(clk), .rst(rst), .en(en),
        .period_we(period_we), .period_in(period_in),
        .duty_we(duty_we), .duty_ch(duty_ch), .duty_in(duty_in),
        .center_mode(center_mode),
        .pwm_out(pwm3), .period_tick(tick3)
    );

    typedef struct packed {
        logic       tick;
        logic [3:0] pwm;
    } obs_t;

    obs_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         hi_cnt[CH];
    int         tick_cnt;
    int         win_idx;
    int         wt_cycles;
    logic [31:0] pat;

    int   m_pp, m_pa, m_cnt;
    int   m_dp[CH];
    int   m_thr[CH];
    bit   m_mp, m_ma, m_down;
    logic [3:0] m_pwm;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @%0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic bit m_bnd();
        if (m_ma) return m_down && (m_cnt == 0);
        return !m_down && (m_cnt == m_pa - 1);
    endfunction

    task automatic model_reset();
        m_pp = DEF; m_pa = DEF; m_cnt = 0;
        m_mp = 0; m_ma = 0; m_down = 0; m_pwm = '0;
        for (int i = 0; i < CH; i++) begin
            m_dp[i] = 0; m_thr[i] = 0;
        end
    endtask

    // Reference behaviour for one clock edge, using inputs held over it.
    task automatic model_step();
        int p;
        bit b;
        logic [3:0] npwm;
        p = m_pa;
        b = en && m_bnd();
        for (int i = 0; i < CH; i++) begin
            if (m_ma) npwm[i] = en && (m_cnt >= p - m_thr[i]);
            else      npwm[i] = en && (m_cnt < m_thr[i]);
        end
        if (!en) begin
            m_cnt = 0; m_down = 0;
        end else if (m_down) begin
            if (m_cnt == 0) m_down = 0;
            else m_cnt--;
        end else if (m_cnt == p - 1) begin
            if (m_ma) m_down = 1;
            else m_cnt = 0;
        end else begin
            m_cnt++;
        end
        if (!en || b) begin
            for (int i = 0; i < CH; i++) begin
                if (m_dp[i] == 255) m_thr[i] = m_pp;
                else m_thr[i] = (m_pp * m_dp[i]) >> 8;
            end
            m_pa = m_pp;
            m_ma = m_mp;
        end
        if (period_we) m_pp = (period_in < 2) ? 2 : int'(period_in);
        if (duty_we) m_dp[duty_ch] = int'(duty_in);
        m_mp = center_mode;
        m_pwm = npwm;
        sb_q.push_back(obs_t'({en && m_bnd(), m_pwm}));
    endtask

    task automatic cyc();
        obs_t e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        e = sb_q.pop_front();
        check("out", {27'd0, period_tick, pwm_out}, {27'd0, e});
        check("out3", {28'd0, tick3, pwm3}, {28'd0, e.tick, e.pwm[2:0]});
        if (period_tick) tick_cnt++;
        for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm_out[i]);
        if (win_idx < 32) pat[win_idx] = pwm_out[0];
        win_idx++;
    endtask

    task automatic clear_win();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        tick_cnt = 0; win_idx = 0; pat = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wait_tick(input int lim);
        wt_cycles = 0;
        do begin
            cyc();
            wt_cycles++;
        end while (!period_tick && wt_cycles < lim);
        check("tick_wait", {31'd0, period_tick}, 32'd1);
    endtask

    task automatic wr_duty(input int ch, input int val);
        duty_we = 1'b1; duty_ch = 2'(ch); duty_in = DW'(val);
        cyc();
        duty_we = 1'b0;
    endtask

    task automatic wr_period(input int v);
        period_we = 1'b1; period_in = CW'(v);
        cyc();
        period_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pat;
        model_reset();
        clear_win();
        repeat (2) @(negedge clk);
        check("rst_pwm", {28'd0, pwm_out}, 32'd0);
        check("rst_tick", {31'd0, period_tick}, 32'd0);
        rst = 1'b0;

        // Default period, ch0 half duty
        wr_duty(0, 128);
        cyc();
        en = 1'b1;
        wait_tick(3000);
        check("t1_first_tick", wt_cycles, 2499);
        cyc(); clear_win(); run(2500);
        check("t1_hi0", hi_cnt[0], 1250);
        check("t1_others", hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("t1_ticks", tick_cnt, 1);

        // Full and zero duty
        wr_duty(1, 255);
        wr_duty(2, 0);
        wait_tick(3000); wait_tick(3000);
        cyc(); clear_win(); run(2500);
        check("t2_hi1", hi_cnt[1], 2500);
        check("t2_hi2", hi_cnt[2], 0);
        check("t2_hi0", hi_cnt[0], 1250);

        // Mid-period duty write applies at the next boundary
        wr_duty(0, 64);
        wait_tick(3000);
        cyc(); clear_win();
        for (int k = 0; k < 2500; k++) begin
            if (k == 1000) begin
                duty_we = 1'b1; duty_ch = 2'd0; duty_in = 8'd192;
            end
            cyc();
            duty_we = 1'b0;
        end
        check("t3_hi_old", hi_cnt[0], 625);
        check("t3_ticks_old", tick_cnt, 1);
        clear_win(); run(2500);
        check("t3_hi_new", hi_cnt[0], 1875);
        check("t3_ticks_new", tick_cnt, 1);

        // Center-aligned, period 10
        en = 1'b0;
        wr_period(10);
        wr_duty(0, 128);
        center_mode = 1'b1;
        cyc(); cyc();
        en = 1'b1;
        wait_tick(40);
        check("t4_first_tick", wt_cycles, 19);
        cyc(); clear_win(); run(20);
        check("t4_hi0", hi_cnt[0], 10);
        check("t4_hi1", hi_cnt[1], 20);
        check("t4_hi2", hi_cnt[2], 0);
        check("t4_ticks", tick_cnt, 1);
        exp_pat = '0;
        for (int k = 5; k <= 14; k++) exp_pat[k] = 1'b1;
        check("t4_pattern", pat & 32'hF_FFFF, exp_pat);

        // Period clamp and out-of-range channel on the 3-channel instance
        en = 1'b0;
        center_mode = 1'b0;
        wr_period(1);
        cyc();
        en = 1'b1;
        wait_tick(10);
        cyc(); clear_win(); run(8);
        check("t5_ticks", tick_cnt, 4);
        check("t5_hi1", hi_cnt[1], 8);
        check("t5_hi0", hi_cnt[0], 4);
        wr_duty(3, 255);
        wait_tick(10); wait_tick(10);
        cyc(); clear_win(); run(8);
        check("t5_hi3", hi_cnt[3], 8);

        // Asynchronous reset with outputs high
        en = 1'b0;
        wr_period(2500);
        wr_duty(0, 192);
        cyc();
        en = 1'b1;
        run(1702);
        check("t6_high", {31'd0, pwm_out[0]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_pwm", {28'd0, pwm_out}, 32'd0);
        check("t6_rst_tick", {31'd0, period_tick}, 32'd0);
        model_reset();
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        wait_tick(2600);
        check("t6_first_tick", wt_cycles, 2499);
        cyc(); clear_win(); run(2500);
        check("t6_hi_all", hi_cnt[0] + hi_cnt[1] + hi_cnt[2] + hi_cnt[3], 0);
        check("t6_ticks", tick_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
